// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    OUT,
    DRAIN
  } fetch_state_t;

  localparam int          INSTR_BYTES          = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          DEFAULT_TIMEOUT      = 16;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Cycle counter bounding how long the sequencer waits for a memory response.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CW'(1);
  end

  // Fires on the cycle whose increment would reach TIMEOUT.
  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives PC updates, issues one imem request at a time and
// buffers one instruction for decode, with trap/redirect flushing.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEFAULT_TRAP_VECTOR),
  parameter int               TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_out,
  output logic             pc_en,
  output logic [WIDTH-1:0] pc_next,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             decode_stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             trap,
  output logic             fetch_err
);

  fetch_state_t state, state_next;
  logic         redir_any, misaligned, outstanding, counting, expired, fetch_err_next;

  assign counting    = (state == WAIT) || (state == DRAIN);
  assign redir_any   = (state != BOOT) && (trap || redirect_valid);
  assign misaligned  = (state != BOOT) && !trap && redirect_valid && (redirect_target[1:0] != 2'b00);
  // A response that lands together with the redirect is simply dropped.
  assign outstanding = (state == REQ && imem_gnt) || (counting && !imem_rvalid);
  assign imem_addr   = pc_out;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (redir_any || !counting),
    .enable  (counting),
    .expired (expired)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= state_next;
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    if (redir_any) begin
      state_next = outstanding ? DRAIN : REQ;
    end else begin
      case (state)
        BOOT:    state_next = REQ;
        REQ:     if (imem_gnt) state_next = WAIT;
        WAIT:    if (imem_rvalid) state_next = OUT;
                 else if (expired) state_next = REQ;
        OUT:     if (!decode_stall) state_next = REQ;
        DRAIN:   if (imem_rvalid || expired) state_next = REQ;
        default: state_next = BOOT;
      endcase
    end
  end

  always_comb begin
    pc_en          = 1'b0;
    pc_next        = pc_out + WIDTH'(INSTR_BYTES);
    imem_req       = 1'b0;
    fetch_err_next = 1'b0;
    case (state)
      BOOT: begin
        pc_en   = rst;
        pc_next = RESET_VECTOR;
      end
      REQ:  imem_req = 1'b1;
      WAIT: if (!imem_rvalid && expired) begin
        pc_en          = 1'b1;
        pc_next        = TRAP_VECTOR;
        fetch_err_next = 1'b1;
      end
      OUT:   pc_en = !decode_stall;
      DRAIN: fetch_err_next = !imem_rvalid && expired;
      default: ;
    endcase
    if (redir_any) begin
      pc_en          = 1'b1;
      pc_next        = (trap || misaligned) ? TRAP_VECTOR : redirect_target;
      fetch_err_next = misaligned;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_err   <= 1'b0;
    end else begin
      fetch_err <= fetch_err_next;
      if (redir_any) begin
        instr_valid <= 1'b0;
      end else if (state == WAIT && imem_rvalid) begin
        instr_valid <= 1'b1;
        instr       <= imem_rdata;
        instr_pc    <= pc_out;
      end else if (state == OUT && !decode_stall) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an external PC register and a simple
// one-outstanding instruction memory whose rdata encodes the fetch address.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_out;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, fetch_err;
  logic [31:0] instr, instr_pc;
  logic        decode_stall = 1'b0, redirect_valid = 1'b0, trap = 1'b0;
  logic [31:0] redirect_target = '0;

  logic        gnt_en = 1'b0, rv_en = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] addr_q = '0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .pc_en(pc_en), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .decode_stall(decode_stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap(trap), .fetch_err(fetch_err)
  );

  // PC register the sequencer steers; nonzero reset value exposes the BOOT load.
  always @(posedge clk or negedge rst) begin
    if (!rst)       pc_out <= 32'h0000_0A00;
    else if (pc_en) pc_out <= pc_next;
  end

  // Memory: grant follows request when enabled; response held until delivered.
  assign imem_gnt    = imem_req & gnt_en;
  assign imem_rvalid = pend & rv_en;
  assign imem_rdata  = 32'h0000_0013 ^ (addr_q << 12);
  always @(posedge clk) begin
    if (imem_gnt) begin
      pend   <= 1'b1;
      addr_q <= imem_addr;
    end else if (imem_rvalid) begin
      pend <= 1'b0;
    end
  end

  typedef struct {
    logic        gnt, rv, stall, redir, trp;
    logic [31:0] tgt;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc, ins;
    logic        ferr;
  } vec_t;

  function automatic vec_t mk(logic gnt, logic rv, logic stall, logic redir, logic trp,
                              logic [31:0] tgt, logic e_pc_en, logic [31:0] e_pc_next,
                              logic e_req, logic [31:0] e_addr, logic e_iv,
                              logic [31:0] e_ipc, logic [31:0] e_ins, logic e_ferr);
    vec_t v;
    v.gnt = gnt;  v.rv = rv;  v.stall = stall;  v.redir = redir;  v.trp = trp;  v.tgt = tgt;
    v.pc_en = e_pc_en;  v.pc_next = e_pc_next;  v.req = e_req;  v.addr = e_addr;
    v.iv = e_iv;  v.ipc = e_ipc;  v.ins = e_ins;  v.ferr = e_ferr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then compare outputs.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    gnt_en = v.gnt;  rv_en = v.rv;  decode_stall = v.stall;
    redirect_valid = v.redir;  trap = v.trp;  redirect_target = v.tgt;
    #1;
    check({tag, ".pc_en"}, 32'(pc_en), 32'(v.pc_en));
    if (v.pc_en) check({tag, ".pc_next"}, pc_next, v.pc_next);
    check({tag, ".imem_req"}, 32'(imem_req), 32'(v.req));
    if (v.req) check({tag, ".imem_addr"}, imem_addr, v.addr);
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'(v.iv));
    if (v.iv) begin
      check({tag, ".instr_pc"}, instr_pc, v.ipc);
      check({tag, ".instr"}, instr, v.ins);
    end
    check({tag, ".fetch_err"}, 32'(fetch_err), 32'(v.ferr));
  endtask

  vec_t tbl[$];

  initial begin
    // Boot and sequential fetch at 3-cycle spacing
    tbl.push_back(mk(1,1,0,0,0,0,            1,32'h0,    0,0,        0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,0,        1,32'h0,    0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,0,        0,0,        0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            1,32'h4,    0,0,        1,32'h0,32'h13,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,0,        1,32'h4,    0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,0,        0,0,        0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            1,32'h8,    0,0,        1,32'h4,32'h4013,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,0,        1,32'h8,    0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,0,        0,0,        0,0,0,0));
    // Decode stall for five cycles, then release
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,1,1,0,0,0,          0,0,        0,0,        1,32'h8,32'h8013,0));
    tbl.push_back(mk(1,1,0,0,0,0,            1,32'hC,    0,0,        1,32'h8,32'h8013,0));
    // Redirect while the response is pending: drain and drop it
    tbl.push_back(mk(1,1,0,0,0,0,            0,0,        1,32'hC,    0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,32'h40,       1,32'h40,   0,0,        0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,0,        0,0,        0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,0,        1,32'h40,   0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,0,        0,0,        0,0,0,0));
    // Trap beats redirect and flushes a stalled instruction
    tbl.push_back(mk(1,1,1,1,1,32'h80,       1,32'h100,  0,0,        1,32'h40,32'h40013,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,0,        1,32'h100,  0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,0,        0,0,        0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            1,32'h104,  0,0,        1,32'h100,32'h100013,0));
    // Misaligned redirect: trap vector and a single fetch_err pulse
    tbl.push_back(mk(0,1,0,1,0,32'h42,       1,32'h100,  1,32'h104,  0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,            0,0,        1,32'h100,  0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,            0,0,        1,32'h100,  0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,            0,0,        1,32'h100,  0,0,0,0));

    #2 rst = 1'b0;
    #1;
    check("reset.pc_en", 32'(pc_en), 32'd0);
    check("reset.imem_req", 32'(imem_req), 32'd0);
    check("reset.instr_valid", 32'(instr_valid), 32'd0);
    check("reset.fetch_err", 32'(fetch_err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));

    // Timeout: response never arrives; trap redirect on the 16th WAIT cycle
    for (int i = 0; i < 16; i++)
      step(mk(1,0,0,0,0,0, (i == 15),32'h100, 0,0, 0,0,0,0), $sformatf("tmo%0d", i));
    step(mk(0,0,0,0,0,0, 0,0, 1,32'h100, 0,0,0,1), "tmo_err");
    step(mk(1,0,0,0,0,0, 0,0, 1,32'h100, 0,0,0,0), "tmo_refetch");
    step(mk(1,0,0,0,0,0, 0,0, 0,0,       0,0,0,0), "wait_a");
    step(mk(1,0,0,0,0,0, 0,0, 0,0,       0,0,0,0), "wait_b");

    // Reset in the middle of WAIT: outputs drop without waiting for a clock
    #2 rst = 1'b0;
    #1;
    check("midrst.pc_en", 32'(pc_en), 32'd0);
    check("midrst.imem_req", 32'(imem_req), 32'd0);
    check("midrst.instr_valid", 32'(instr_valid), 32'd0);
    check("midrst.instr", instr, 32'h0);
    check("midrst.instr_pc", instr_pc, 32'h0);
    check("midrst.fetch_err", 32'(fetch_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Late response lands in BOOT and must be ignored
    step(mk(1,1,0,0,0,0, 1,32'h0, 0,0, 0,0,0,0), "reboot");
    step(mk(1,1,0,0,0,0, 0,0, 1,32'h0, 0,0,0,0), "reboot_req");
    step(mk(1,1,0,0,0,0, 0,0, 0,0,     0,0,0,0), "reboot_wait");
    // Redirect to the top word, then check the +4 wrap to zero
    step(mk(1,1,1,1,0,32'hFFFF_FFFC, 1,32'hFFFF_FFFC, 0,0, 1,32'h0,32'h13,0), "wrap_redir");
    step(mk(1,1,0,0,0,0, 0,0, 1,32'hFFFF_FFFC, 0,0,0,0), "wrap_req");
    step(mk(1,1,0,0,0,0, 0,0, 0,0, 0,0,0,0), "wrap_wait");
    step(mk(1,1,0,0,0,0, 1,32'h0, 0,0, 1,32'hFFFF_FFFC,32'hFFFF_C013,0), "wrap_out");
    step(mk(0,1,0,0,0,0, 0,0, 1,32'h0, 0,0,0,0), "wrap_next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
